tx_re_mapper: RTL and testbench
===============================

TX_RE_MAPPER -- requirements
Module: tx_re_mapper

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the width of one real or imaginary component in Q4.12.
REQ-002 SHALL have parameter NUM_SC, default 12, the number of subcarriers per SC-FDMA symbol.
REQ-003 SHALL have port i_clk_map, input, 1 bit: the single block clock, rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_start, input, 1 bit: one-cycle pulse that starts one slot.
REQ-006 SHALL have port i_data, input, 2*DATA_WIDTH bits: serial data subcarrier, packed {re,im}.
REQ-007 SHALL have port i_data_valid, input, 1 bit: i_data is valid this cycle.
REQ-008 SHALL have port i_pilot, input, array [NUM_SC-1:0] of 2*DATA_WIDTH bits: DMRS vector, held stable for the whole slot.
REQ-009 SHALL have port o_ready, output, 1 bit: the block accepts i_data this cycle.
REQ-010 SHALL have port o_sym, output, array [NUM_SC-1:0] of 2*DATA_WIDTH bits: parallel symbol vector.
REQ-011 SHALL have port o_sym_valid, output, 1 bit: one-cycle strobe that qualifies o_sym.
REQ-012 SHALL have port o_symbol_num, output, 3 bits: symbol index 1..7, valid while o_sym_valid is high.
REQ-013 SHALL have port o_done_slot, output, 1 bit: one-cycle pulse that coincides with symbol 7.
REQ-014 SHALL have port o_err, output, 1 bit: sticky overflow flag (see REQ-029).

Function
REQ-015 SHALL implement a state machine with the states IDLE, COLLECT, EMIT_DATA, EMIT_PILOT.
REQ-016 SHALL move from IDLE to COLLECT on i_start and set the symbol counter to 1; in IDLE, o_ready=0.
REQ-017 SHALL, in COLLECT, hold o_ready=1 and accept a word when i_data_valid && o_ready; the word is stored at subcarrier index k, which counts 0..NUM_SC-1.
REQ-018 SHALL, when word k=NUM_SC-1 is accepted at edge N, go to EMIT_DATA, drive o_sym_valid=1 with the collected vector in the cycle after edge N (latency 1), and reset k to 0.
REQ-019 SHALL hold o_ready=0 in EMIT_DATA and EMIT_PILOT; no input word is consumed there.
REQ-020 SHALL, after emitting symbol 3, go to EMIT_PILOT and output o_sym=i_pilot with o_symbol_num=4 in the very next cycle, consuming no data.
REQ-021 SHALL carry the data symbols as symbol numbers 1,2,3,5,6,7 (6*NUM_SC=72 data words per slot); symbol 4 is always the pilot.
REQ-022 SHALL assert o_done_slot together with the emission of symbol 7, then return to IDLE.
REQ-023 SHALL, after any other emission, return to COLLECT with the symbol counter incremented.
REQ-024 SHALL ignore i_start whenever the state is not IDLE.
REQ-025 SHALL ignore i_data_valid when o_ready=0; a partial symbol stays held indefinitely while i_data_valid is low (no timeout).
REQ-026 SHALL hold o_sym at its last emitted value between strobes.
REQ-027 SHALL pass data through bit-exact: no scaling, rounding or reordering; the word at index k appears on o_sym[k].

Reset
REQ-028 SHALL, while i_rst_n=0 (asynchronously), force: state IDLE, k=0, symbol counter 0, o_sym all zero, o_sym_valid=0, o_symbol_num=0, o_done_slot=0, o_ready=0, o_err=0; reset mid-slot discards the partial symbol.

Configuration
REQ-029 SHALL, when macro TX_MAP_OVF_CHK_EN is defined, set o_err=1 on any cycle where i_data_valid=1 and o_ready=0 while the state is not IDLE; o_err is cleared only by reset. Without the macro, o_err SHALL be a constant 0 and no checking logic is built.

Structure
REQ-030 SHALL take from shared package tx_map_pkg: the state enum, NUM_SYM=7, PILOT_SYM=4 and NUM_SC_DEF=12.
REQ-031 SHALL place the k counter and the parallel register file in one sub-module, tx_map_collect; the FSM and the symbol counter sit in the top level.

Verification
REQ-032 Shall cover: i_start, then 72 words with i_data_valid=1 every ready cycle, values {k,sym} -> 7 strobes, numbers 1,2,3,4,5,6,7; strobe 4 equals i_pilot; o_done_slot high only with symbol 7.
REQ-033 Shall cover: the 12th word of symbol 1 accepted at edge N -> o_sym_valid at cycle N+1; o_ready=0 for that cycle; o_sym[11]=12th word.
REQ-034 Shall cover: i_data_valid toggling 1/0 every cycle -> output identical to REQ-032, with each symbol taking 24 cycles.
REQ-035 Shall cover: i_start pulsed during COLLECT of symbol 2 -> no effect; the slot completes normally.
REQ-036 Shall cover: reset asserted after 30 words -> all outputs zero immediately; a new i_start restarts at symbol 1, k=0.
REQ-037 Shall cover, with TX_MAP_OVF_CHK_EN defined: i_data_valid=1 during the EMIT_PILOT cycle -> o_err=1 and stays 1; without the macro, o_err stays 0.

Source files
------------

// File: rtl/tx_map_pkg.sv
// rtl/tx_map_pkg.sv - shared types and constants for the TX resource-element mapper
//
// Purpose: the FSM state encoding and the slot geometry that tx_re_mapper and
// tx_map_collect agree on. No ports.
//   state_t     : IDLE / COLLECT / EMIT_DATA / EMIT_PILOT
//   NUM_SYM     : SC-FDMA symbols per slot
//   PILOT_SYM   : symbol index that carries the DMRS vector
//   NUM_SC_DEF  : default subcarriers per symbol
package tx_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_COLLECT    = 2'd1,
    ST_EMIT_DATA  = 2'd2,
    ST_EMIT_PILOT = 2'd3
  } state_t;

  localparam int NUM_SYM    = 7;
  localparam int PILOT_SYM  = 4;
  localparam int NUM_SC_DEF = 12;

endpackage

// File: rtl/tx_map_collect.sv
// rtl/tx_map_collect.sv - serial-to-parallel subcarrier collector (k counter + register file)
//
// Purpose: stores accepted serial words at subcarrier index k and presents the
// complete vector, including the word being accepted this cycle, so the parent
// can register a full symbol on the same edge that takes the last word.
// Ports:
//   clk, rst_n : block clock, asynchronous active-low reset
//   clear      : forces k back to 0 (parent holds it while idle)
//   accept     : data is written at index k this edge
//   data       : serial word being offered
//   last       : k points at the final subcarrier
//   vec_next   : stored words with index k replaced by data
module tx_map_collect
  import tx_map_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NUM_SC = NUM_SC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [WORD_W-1:0] data,
  output logic              last,
  output logic [WORD_W-1:0] vec_next [NUM_SC-1:0]
);

  localparam int KW = (NUM_SC > 1) ? $clog2(NUM_SC) : 1;

  logic [KW-1:0]     k;
  logic [WORD_W-1:0] regs [NUM_SC-1:0];

  assign last = (k == KW'(NUM_SC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= '0;
      regs <= '{default: '0};
    end else if (clear) begin
      k <= '0;
    end else if (accept) begin
      regs[k] <= data;
      k       <= last ? '0 : k + KW'(1);
    end
  end

  // Bypass the incoming word into its slot so the symbol is complete on the
  // accepting edge rather than one cycle later.
  always_comb begin
    for (int i = 0; i < NUM_SC; i++) begin
      vec_next[i] = (k == KW'(i)) ? data : regs[i];
    end
  end

endmodule

// File: rtl/tx_re_mapper.sv
// rtl/tx_re_mapper.sv - SC-FDMA resource-element mapper: 6 data symbols plus DMRS pilot per slot
//
// Purpose: collects serial {re,im} data words into NUM_SC-wide symbols and
// emits a 7-symbol slot (1,2,3,pilot,5,6,7) as one-cycle parallel strobes.
// Optional feature macro: TX_MAP_OVF_CHK_EN builds the sticky overflow
// detector on o_err; without it o_err is tied to 0.
// Ports:
//   i_clk_map, i_rst_n : block clock, asynchronous active-low reset
//   i_start            : one-cycle slot start (honoured only in IDLE)
//   i_data/i_data_valid: serial data subcarrier, packed {re,im}
//   i_pilot            : DMRS vector, stable for the slot
//   o_ready            : word accepted when i_data_valid && o_ready
//   o_sym/o_sym_valid  : parallel symbol and its one-cycle strobe
//   o_symbol_num       : 1..7 alongside o_sym_valid
//   o_done_slot        : pulses with symbol 7
//   o_err              : sticky overflow flag
module tx_re_mapper
  import tx_map_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SC     = NUM_SC_DEF
) (
  input  logic                    i_clk_map,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [2*DATA_WIDTH-1:0] i_data,
  input  logic                    i_data_valid,
  input  logic [2*DATA_WIDTH-1:0] i_pilot [NUM_SC-1:0],
  output logic                    o_ready,
  output logic [2*DATA_WIDTH-1:0] o_sym [NUM_SC-1:0],
  output logic                    o_sym_valid,
  output logic [2:0]              o_symbol_num,
  output logic                    o_done_slot,
  output logic                    o_err
);

  localparam logic [2:0] SYM_LAST   = 3'(NUM_SYM);
  localparam logic [2:0] SYM_PILOT  = 3'(PILOT_SYM);
  localparam logic [2:0] SYM_PRE_PL = 3'(PILOT_SYM - 1);

  state_t                  state;
  logic [2:0]              sym_cnt;
  logic                    accept;
  logic                    last;
  logic [2*DATA_WIDTH-1:0] vec_next [NUM_SC-1:0];

  // o_ready is only ever high in COLLECT, so this also gates by state.
  assign accept = i_data_valid && o_ready;

  tx_map_collect #(
    .WORD_W (2*DATA_WIDTH),
    .NUM_SC (NUM_SC)
  ) u_collect (
    .clk      (i_clk_map),
    .rst_n    (i_rst_n),
    .clear    (state == ST_IDLE),
    .accept   (accept),
    .data     (i_data),
    .last     (last),
    .vec_next (vec_next)
  );

  always_ff @(posedge i_clk_map or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      sym_cnt      <= 3'd0;
      o_ready      <= 1'b0;
      o_sym        <= '{default: '0};
      o_sym_valid  <= 1'b0;
      o_symbol_num <= 3'd0;
      o_done_slot  <= 1'b0;
    end else begin
      o_sym_valid <= 1'b0;
      o_done_slot <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state   <= ST_COLLECT;
            sym_cnt <= 3'd1;
            o_ready <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (accept && last) begin
            state        <= ST_EMIT_DATA;
            o_ready      <= 1'b0;
            o_sym        <= vec_next;
            o_sym_valid  <= 1'b1;
            o_symbol_num <= sym_cnt;
            o_done_slot  <= (sym_cnt == SYM_LAST);
          end
        end
        // The data strobe is visible during this state; decide what follows it.
        ST_EMIT_DATA: begin
          if (sym_cnt == SYM_PRE_PL) begin
            state        <= ST_EMIT_PILOT;
            sym_cnt      <= SYM_PILOT;
            o_sym        <= i_pilot;
            o_sym_valid  <= 1'b1;
            o_symbol_num <= SYM_PILOT;
          end else if (sym_cnt == SYM_LAST) begin
            state   <= ST_IDLE;
            sym_cnt <= 3'd0;
          end else begin
            state   <= ST_COLLECT;
            sym_cnt <= sym_cnt + 3'd1;
            o_ready <= 1'b1;
          end
        end
        ST_EMIT_PILOT: begin
          state   <= ST_COLLECT;
          sym_cnt <= sym_cnt + 3'd1;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef TX_MAP_OVF_CHK_EN
  // Sticky: a word offered while the block is busy emitting is lost.
  always_ff @(posedge i_clk_map or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else if ((state != ST_IDLE) && i_data_valid && !o_ready) begin
      o_err <= 1'b1;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_re_mapper.sv
// tb/tb_tx_re_mapper.sv - scoreboard bench for tx_re_mapper (default build or TX_MAP_OVF_CHK_EN)
`timescale 1ns/1ps
module tb_tx_re_mapper;

  localparam int DW  = 16;
  localparam int NSC = 12;
  localparam int WW  = 2*DW;

  typedef struct packed {
    logic [NSC*WW-1:0] v;
    logic [2:0]        num;
    logic              done;
  } exp_t;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic [WW-1:0] data   = '0;
  logic          dvalid = 1'b0;
  logic [WW-1:0] pilot [NSC-1:0];
  logic          ready;
  logic [WW-1:0] sym [NSC-1:0];
  logic          sym_valid;
  logic [2:0]    sym_num;
  logic          done;
  logic          err;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  tx_re_mapper #(.DATA_WIDTH(DW), .NUM_SC(NSC)) dut (
    .i_clk_map    (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_data       (data),
    .i_data_valid (dvalid),
    .i_pilot      (pilot),
    .o_ready      (ready),
    .o_sym        (sym),
    .o_sym_valid  (sym_valid),
    .o_symbol_num (sym_num),
    .o_done_slot  (done),
    .o_err        (err)
  );

  function automatic logic [WW-1:0] word_of(input logic [7:0] salt, input int k, input int s);
    return {salt, 8'(k), 16'(s)};
  endfunction

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (sym_valid) begin : chk
        exp_t e;
        bit   bad;
        int   bad_i;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL strobe_unexpected: got symbol %0d, required no strobe", sym_num);
        end else begin
          e = sb.pop_front();
          bad = 1'b0;
          bad_i = 0;
          for (int i = 0; i < NSC; i++)
            if (!bad && sym[i] !== e.v[i*WW +: WW]) begin bad = 1'b1; bad_i = i; end
          n_vec++;
          if (bad) begin
            n_err++;
            $display("FAIL strobe_vec: symbol %0d sc %0d got %h required %h",
                     e.num, bad_i, sym[bad_i], e.v[bad_i*WW +: WW]);
          end
          n_vec++;
          if (sym_num !== e.num) begin
            n_err++;
            $display("FAIL strobe_num: got %0d required %0d", sym_num, e.num);
          end
          n_vec++;
          if (done !== e.done) begin
            n_err++;
            $display("FAIL strobe_done: symbol %0d got %b required %b", e.num, done, e.done);
          end
        end
      end else begin
        n_vec++;
        if (done !== 1'b0) begin
          n_err++;
          $display("FAIL done_without_strobe: got %b required 0", done);
        end
      end
    end
  end

  task automatic new_pilot();
    for (int i = 0; i < NSC; i++) pilot[i] = $urandom();
  endtask

  // mode 0: valid exactly on ready cycles; mode 1: valid toggles every cycle.
  task automatic run_slot(input logic [7:0] salt, input int mode, input bit start_mid,
                          input bit err_pilot, input int stop_after);
    exp_t e;
    int   s, k, words, budget;
    bit   phase, v;
    s = 1; k = 0; words = 0; budget = 0; phase = 1'b1;
    @(negedge clk);
    start = 1'b1;
    dvalid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (s <= 7 && words < stop_after && budget < 2000) begin
      data = word_of(salt, k, s);
      if (mode == 1) begin v = phase; phase = !phase; end
      else v = ready;
      if (err_pilot && sym_valid && sym_num == 3'd4) v = 1'b1;
      start = (start_mid && s == 2 && k == 5);
      dvalid = v;
      if (v && ready) begin
        words++;
        if (k == NSC-1) begin
          for (int i = 0; i < NSC; i++) e.v[i*WW +: WW] = word_of(salt, i, s);
          e.num = 3'(s);
          e.done = (s == 7);
          sb.push_back(e);
          if (s == 3) begin
            for (int i = 0; i < NSC; i++) e.v[i*WW +: WW] = pilot[i];
            e.num = 3'd4;
            e.done = 1'b0;
            sb.push_back(e);
          end
          k = 0;
          s = (s == 3) ? 5 : s + 1;
        end else begin
          k++;
        end
      end
      @(negedge clk);
      budget++;
    end
    dvalid = 1'b0;
    start = 1'b0;
    n_vec++;
    if (budget >= 2000) begin
      n_err++;
      $display("FAIL slot_timeout: %0d words accepted, required %0d", words, stop_after);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 40) begin @(negedge clk); b++; end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d strobes outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    bit nz;
    nz = 1'b0;
    for (int i = 0; i < NSC; i++) if (sym[i] !== '0) nz = 1'b1;
    n_vec++;
    if (nz) begin n_err++; $display("FAIL %s_sym: got nonzero o_sym required all zero", tag); end
    n_vec++;
    if ({ready, sym_valid, sym_num, done, err} !== 7'd0) begin
      n_err++;
      $display("FAIL %s_ctl: got rdy=%b vld=%b num=%0d done=%b err=%b required all 0",
               tag, ready, sym_valid, sym_num, done, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    new_pilot();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b required 0", ready); end
  endtask

  task automatic test_idle_ignore();
    for (int c = 0; c < 4; c++) begin
      data = word_of(8'hEE, c, 1);
      dvalid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (ready !== 1'b0) begin n_err++; $display("FAIL idle_ignore_ready: got %b required 0", ready); end
    end
    dvalid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL idle_ignore_err: got %b required 0", err); end
  endtask

  task automatic test_full_slot();
    new_pilot();
    run_slot(8'h11, 0, 1'b0, 1'b0, 1000);
    drain();
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL slot_end_ready: got %b required 0", ready); end
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL slot_err: got %b required 0", err); end
  endtask

  task automatic test_latency();
    new_pilot();
    run_slot(8'h5A, 0, 1'b0, 1'b0, NSC);
    // Now one cycle after the edge that took the 12th word.
    n_vec++;
    if (sym_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid: got %b required 1", sym_valid); end
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL lat_ready: got %b required 0", ready); end
    n_vec++;
    if (sym[NSC-1] !== word_of(8'h5A, NSC-1, 1)) begin
      n_err++;
      $display("FAIL lat_last_word: got %h required %h", sym[NSC-1], word_of(8'h5A, NSC-1, 1));
    end
    @(negedge clk);
    n_vec++;
    if ({sym_valid, ready} !== 2'b01) begin
      n_err++;
      $display("FAIL lat_after: got vld=%b rdy=%b required vld=0 rdy=1", sym_valid, ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_toggle();
    new_pilot();
    run_slot(8'h22, 1, 1'b0, 1'b0, 1000);
    drain();
  endtask

  task automatic test_start_ignored();
    new_pilot();
    run_slot(8'h33, 0, 1'b1, 1'b0, 1000);
    drain();
  endtask

  task automatic test_reset_mid();
    new_pilot();
    run_slot(8'h44, 0, 1'b0, 1'b0, 30);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_pending: got %0d strobes outstanding required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    new_pilot();
    run_slot(8'h55, 0, 1'b0, 1'b0, 1000);
    drain();
  endtask

  task automatic test_ovf();
    new_pilot();
    run_slot(8'h66, 0, 1'b0, 1'b1, 1000);
    drain();
`ifdef TX_MAP_OVF_CHK_EN
    n_vec++;
    if (err !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b required 1", err); end
    repeat (5) @(negedge clk);
    n_vec++;
    if (err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b required 1", err); end
`else
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL ovf_off: got %b required 0", err); end
`endif
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_slot();
    test_latency();
    test_toggle();
    test_start_ignored();
    test_reset_mid();
    test_ovf();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
